// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seg_pkg;

    typedef enum logic {
        ST_ON  = 1'b0,
        ST_GAP = 1'b1
    } seg_state_t;

    localparam int                      SEG_NIBBLE_W   = 4;
    localparam logic [SEG_NIBBLE_W-1:0] SEG_BLANK_CODE = 4'hF;

endpackage

// File: rtl/seg_phase_timer.sv
// Phase counter for the scan controller: counts ON/GAP dwell, flags terminal
// count and advances the digit index (with wrap) at the end of each gap.
module seg_phase_timer #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_MAX    = 50000,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 16,
    parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_gap,
    output logic             tc,
    output logic             frame_start,
    output logic [IDX_W-1:0] idx_nxt
);

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             last_idx;

    assign last_idx    = (idx == IDX_W'(NUM_DIGITS - 1));
    assign tc          = in_gap ? (cnt == CNT_W'(GAP_CYCLES - 1))
                                : (cnt == CNT_W'(DIV_MAX - 1));
    assign frame_start = tc && in_gap && last_idx;
    assign idx_nxt     = (tc && in_gap) ? (last_idx ? '0 : idx + IDX_W'(1)) : idx;

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= IDX_W'(NUM_DIGITS - 1);
        end else begin
            cnt <= tc ? '0 : cnt + CNT_W'(1);
            idx <= idx_nxt;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-aligned LOAD/ACK update.
// Define SEG_LZB_EN to enable leading-zero blanking (digit 0 never blanked).
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_MAX    = 50000,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           LOAD,
    input  logic [4*NUM_DIGITS-1:0]        DIN,
    output logic                           ACK,
    output logic                           BUSY,
    output logic [SEG_NIBBLE_W-1:0]        BCD,
    output logic [NUM_DIGITS-1:0]          DIG_EN
);

    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int WORD_W = SEG_NIBBLE_W * NUM_DIGITS;

    seg_state_t              state;
    seg_state_t              state_nxt;
    logic [WORD_W-1:0]       disp;
    logic [WORD_W-1:0]       disp_nxt;
    logic [WORD_W-1:0]       pending;
    logic                    tc;
    logic                    frame_start;
    logic                    apply;
    logic [IDX_W-1:0]        idx_nxt;
    logic [NUM_DIGITS-1:0]   blank;
    logic [SEG_NIBBLE_W-1:0] nib_nxt;

    seg_phase_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .DIV_MAX    (DIV_MAX),
        .GAP_CYCLES (GAP_CYCLES),
        .CNT_W      (CNT_W),
        .IDX_W      (IDX_W)
    ) u_timer (
        .clk         (CLK),
        .rst         (RST),
        .in_gap      (state == ST_GAP),
        .tc          (tc),
        .frame_start (frame_start),
        .idx_nxt     (idx_nxt)
    );

    // A pending word only lands on the GAP->ON edge that restarts digit 0.
    assign apply    = frame_start && BUSY;
    assign disp_nxt = apply ? pending : disp;
    assign nib_nxt  = disp_nxt[idx_nxt*SEG_NIBBLE_W +: SEG_NIBBLE_W];

    always_comb begin
        state_nxt = state;
        if (tc) state_nxt = (state == ST_ON) ? ST_GAP : ST_ON;
    end

`ifdef SEG_LZB_EN
    always_comb begin
        logic zeros_above;
        // NOTE: every output of a combinational block gets a default first so
        // no path through the loop leaves it unassigned and infers a latch.
        zeros_above = 1'b1;
        blank       = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zeros_above = zeros_above && (disp_nxt[i*SEG_NIBBLE_W +: SEG_NIBBLE_W] == '0);
            blank[i]    = zeros_above;
        end
    end
`else
    assign blank = '0;
`endif

    // Outputs are registered from next-state values so they line up with the
    // state register while staying free of input-to-output paths.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_GAP;
            // NOTE: the display word is reset to blank codes rather than left
            // undefined, so a reset always reverts the bank to all-off digits.
            disp    <= {NUM_DIGITS{SEG_BLANK_CODE}};
            pending <= '0;
            BUSY    <= 1'b0;
            ACK     <= 1'b0;
            DIG_EN  <= '0;
            BCD     <= SEG_BLANK_CODE;
        end else begin
            state <= state_nxt;
            disp  <= disp_nxt;
            if (LOAD) pending <= DIN;
            BUSY  <= LOAD || (BUSY && !apply);
            ACK   <= apply;
            if (state_nxt == ST_ON) begin
                DIG_EN <= NUM_DIGITS'(1) << idx_nxt;
                BCD    <= blank[idx_nxt] ? SEG_BLANK_CODE : nib_nxt;
            end else begin
                DIG_EN <= '0;
                BCD    <= SEG_BLANK_CODE;
            end
        end
    end

endmodule
